// File: rtl/lsu_dma.sv
// lsu_dma: word-granular copy/fill DMA that borrows the LSU port; fill mode enabled by LSU_DMA_FILL_EN.
module lsu_dma #(
  parameter int LEN_W = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [31:0]      i_src,
  input  logic [31:0]      i_dst,
  input  logic [LEN_W-1:0] i_len,
  input  logic             i_fill,
  input  logic [31:0]      i_fill_data,
  input  logic             i_abort,
  input  logic             i_gnt,
  input  logic [31:0]      i_rdata,
  output logic             o_req,
  output logic [31:0]      o_addr,
  output logic [31:0]      o_wdata,
  output logic [3:0]       o_bmask,
  output logic             o_wren,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic [LEN_W-1:0] o_count
);
  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
  state_t state_q, state_d;
  logic [31:0] src_q, dst_q, buf_q, pat_q;
  logic [LEN_W-1:0] rem_q, count_q;
  logic fill_q, err_q, fill_sel, misalign, rd_go, wr_go, busy;
`ifdef LSU_DMA_FILL_EN
  assign fill_sel = i_fill;
`else
  logic unused_fill;
  assign unused_fill = i_fill;
  assign fill_sel = 1'b0;
`endif
  assign misalign = |{i_src[1:0], i_dst[1:0]};
  // abort wins over grant, so an aborted cycle never touches the bus
  assign busy  = !i_reset && (state_q == RD || state_q == WR);
  assign rd_go = busy && state_q == RD && i_gnt && !i_abort;
  assign wr_go = busy && state_q == WR && i_gnt && !i_abort;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = !i_start ? IDLE : (misalign || i_len == '0) ? DONE : fill_sel ? WR : RD;
      RD:      state_d = i_abort ? DONE : i_gnt ? WR : RD;
      WR:      state_d = i_abort ? DONE : !i_gnt ? WR : rem_q == LEN_W'(1) ? DONE : fill_q ? WR : RD;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    o_req   = busy;
    o_busy  = busy;
    o_done  = !i_reset && state_q == DONE;
    o_err   = !i_reset && err_q;
    o_count = i_reset ? '0 : count_q;
    o_addr  = rd_go ? src_q : wr_go ? dst_q : '0;
    o_wdata = wr_go ? (fill_q ? pat_q : buf_q) : '0;
    o_bmask = rd_go ? 4'b0100 : wr_go ? 4'b1010 : 4'b0000;
    o_wren  = wr_go;
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      buf_q   <= '0;
      pat_q   <= '0;
      rem_q   <= '0;
      count_q <= '0;
      fill_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && i_start) begin
        src_q   <= i_src;
        dst_q   <= i_dst;
        rem_q   <= i_len;
        fill_q  <= fill_sel;
        pat_q   <= i_fill_data;
        count_q <= '0;
        err_q   <= misalign;
      end
      if (rd_go) buf_q <= i_rdata;
      if (wr_go) begin
        src_q   <= src_q + 32'd4;
        dst_q   <= dst_q + 32'd4;
        count_q <= count_q + LEN_W'(1);
        rem_q   <= rem_q - LEN_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_lsu_dma.sv
// tb_lsu_dma: directed + randomized transfers checked against an expected bus-operation list.
module tb_lsu_dma;
  logic clk = 1'b0;
  logic rst, i_start, i_fill, i_abort, i_gnt, o_req, o_wren, o_busy, o_done, o_err;
  logic [31:0] i_src, i_dst, i_fill_data, i_rdata, o_addr, o_wdata;
  logic [15:0] i_len, o_count;
  logic [3:0] o_bmask;
  int nerr = 0, nchk = 0, dc, w;
`ifdef LSU_DMA_FILL_EN
  localparam bit FILL_ON = 1'b1;
`else
  localparam bit FILL_ON = 1'b0;
`endif
  typedef struct {bit wr; logic [31:0] addr; logic [31:0] data;} op_t;
  op_t q[$];
  always #5 clk = ~clk;
  lsu_dma #(.LEN_W(16)) dut (
    .i_clk(clk), .i_reset(rst), .i_start(i_start), .i_src(i_src), .i_dst(i_dst), .i_len(i_len),
    .i_fill(i_fill), .i_fill_data(i_fill_data), .i_abort(i_abort), .i_gnt(i_gnt), .i_rdata(i_rdata),
    .o_req(o_req), .o_addr(o_addr), .o_wdata(o_wdata), .o_bmask(o_bmask), .o_wren(o_wren),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_count(o_count)
  );
  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_1234;
  endfunction
  always_comb i_rdata = mem(o_addr);
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic bit gnt_at(input int gmode, input int c);
    return gmode == 0 ? 1'b1 : gmode == 2 ? !(c >= 2 && c <= 4) : ($urandom_range(0, 3) != 0);
  endfunction
  task automatic check_quiet(input string tag);
    chk({tag, "_req"}, 32'(o_req), 0);
    chk({tag, "_busy"}, 32'(o_busy), 0);
    chk({tag, "_addr"}, o_addr, 0);
    chk({tag, "_wdata"}, o_wdata, 0);
    chk({tag, "_bmask"}, 32'(o_bmask), 0);
    chk({tag, "_wren"}, 32'(o_wren), 0);
  endtask
  task automatic xfer(input logic [31:0] s, input logic [31:0] d, input int len, input int gmode,
                      input int abort_at, input bit fill, input logic [31:0] pat,
                      output int done_c, output int words);
    bit bad, aborted, g, ab;
    op_t op;
    q.delete();
    bad = |{s[1:0], d[1:0]};
    if (!bad)
      for (int i = 0; i < len; i++) begin
        if (FILL_ON && fill) q.push_back('{1'b1, d + 32'(4 * i), pat});
        else begin
          q.push_back('{1'b0, s + 32'(4 * i), 32'h0});
          q.push_back('{1'b1, d + 32'(4 * i), mem(s + 32'(4 * i))});
        end
      end
    @(negedge clk);
    i_start = 1'b1; i_src = s; i_dst = d; i_len = 16'(len); i_fill = fill; i_fill_data = pat;
    i_abort = 1'b0; i_gnt = gnt_at(gmode, 0);
    #1 check_quiet("idle");
    @(posedge clk);
    words = 0; aborted = 1'b0; done_c = -1;
    for (int c = 1; c < 300 && done_c < 0; c++) begin
      @(negedge clk);
      g = gnt_at(gmode, c);
      ab = (c == abort_at);
      i_start = 1'b0; i_gnt = g; i_abort = ab;
      i_src = $urandom; i_dst = $urandom; i_len = 16'($urandom); i_fill_data = $urandom;
      #1;
      if (q.size() == 0 || aborted) begin
        chk("done", 32'(o_done), 1);
        check_quiet("done");
        chk("done_count", 32'(o_count), 32'(words));
        chk("done_err", 32'(o_err), 32'(bad));
        done_c = c;
        i_start = 1'b1; i_src = 32'h3; i_len = 16'd5;
      end else begin
        chk("req", 32'(o_req), 1);
        chk("busy", 32'(o_busy), 1);
        chk("not_done", 32'(o_done), 0);
        if (ab) begin
          chk("abort_wren", 32'(o_wren), 0);
          aborted = 1'b1;
        end else if (g) begin
          op = q.pop_front();
          chk("addr", o_addr, op.addr);
          chk("bmask", 32'(o_bmask), op.wr ? 32'hA : 32'h4);
          chk("wren", 32'(o_wren), 32'(op.wr));
          chk("wdata", o_wdata, op.wr ? op.data : 32'h0);
          if (op.wr) words++;
        end else begin
          chk("stall_bmask", 32'(o_bmask), 0);
          chk("stall_wren", 32'(o_wren), 0);
          chk("stall_addr", o_addr, 0);
        end
      end
      @(posedge clk);
    end
    if (done_c < 0) begin
      nchk++; nerr++;
      $error("FAIL timeout observed=no_done expected=done");
    end
    @(negedge clk);
    i_start = 1'b0; i_abort = 1'b0;
    #1 check_quiet("after");
    chk("after_done", 32'(o_done), 0);
    chk("after_count", 32'(o_count), 32'(words));
    chk("after_err", 32'(o_err), 32'(bad));
  endtask
  initial begin
    rst = 1'b1; i_start = 1'b1; i_src = 32'h100; i_dst = 32'h200; i_len = 16'd3;
    i_fill = 1'b0; i_fill_data = 32'h0; i_abort = 1'b0; i_gnt = 1'b1;
    repeat (2) begin
      @(negedge clk);
      #1 check_quiet("reset");
      chk("reset_done", 32'(o_done), 0);
      chk("reset_err", 32'(o_err), 0);
      chk("reset_count", 32'(o_count), 0);
    end
    @(negedge clk);
    rst = 1'b0; i_start = 1'b0;
    #1 check_quiet("post_reset");
    chk("post_reset_done", 32'(o_done), 0);
    xfer(32'h100, 32'h200, 3, 0, 0, 1'b0, 32'h0, dc, w);
    chk("copy_cycle", 32'(dc), 7); chk("copy_count", 32'(w), 3);
    xfer(32'h300, 32'h400, 2, 2, 0, 1'b0, 32'h0, dc, w);
    chk("stall_cycle", 32'(dc), 8); chk("stall_count", 32'(w), 2);
    xfer(32'h102, 32'h200, 4, 0, 0, 1'b0, 32'h0, dc, w);
    chk("err_cycle", 32'(dc), 1); chk("err_count", 32'(w), 0);
    xfer(32'h100, 32'h202, 4, 0, 0, 1'b0, 32'h0, dc, w);
    chk("derr_cycle", 32'(dc), 1);
    xfer(32'h100, 32'h200, 0, 0, 0, 1'b0, 32'h0, dc, w);
    chk("len0_cycle", 32'(dc), 1);
    xfer(32'h100, 32'h200, 8, 0, 6, 1'b0, 32'h0, dc, w);
    chk("abort_cycle", 32'(dc), 7); chk("abort_count", 32'(w), 2);
    xfer(32'hFFFF_FFFC, 32'h500, 2, 0, 0, 1'b0, 32'h0, dc, w);
    chk("wrap_cycle", 32'(dc), 5);
    xfer(32'h1000, 32'h40, 4, 0, 0, 1'b1, 32'hDEAD_BEEF, dc, w);
    chk("fill_cycle", 32'(dc), FILL_ON ? 5 : 9); chk("fill_count", 32'(w), 4);
    for (int r = 0; r < 30; r++) begin
      logic [31:0] s, d;
      s = $urandom & ~32'h3; d = $urandom & ~32'h3;
      if ($urandom_range(0, 7) == 0) s[0] = 1'b1;
      if ($urandom_range(0, 7) == 0) d[1] = 1'b1;
      xfer(s, d, $urandom_range(0, 6), 1, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 10) : 0,
           1'($urandom), $urandom, dc, w);
    end
    @(negedge clk);
    i_start = 1'b1; i_src = 32'h800; i_dst = 32'h900; i_len = 16'd5; i_gnt = 1'b1; i_fill = 1'b0;
    @(negedge clk);
    i_start = 1'b0;
    repeat (3) @(negedge clk);
    #1 chk("mid_busy", 32'(o_busy), 1);
    i_start = 1'b1; rst = 1'b1;
    #1 check_quiet("mid_reset");
    chk("mid_reset_count", 32'(o_count), 0);
    @(negedge clk);
    rst = 1'b0; i_start = 1'b0;
    #1 check_quiet("mid_after");
    chk("mid_after_done", 32'(o_done), 0);
    chk("mid_after_count", 32'(o_count), 0);
    chk("mid_after_err", 32'(o_err), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/lsu_dma.md
LSU_DMA -- requirements
Module: lsu_dma

Interface
REQ-001 SHALL have parameter LEN_W, default 16, width of length/count fields in words.
REQ-002 SHALL have one clock and a synchronous, active-high reset; ports are named i_clk and i_reset.
REQ-003 i_clk  in  1  sole clock; all state updates on rising edge.
REQ-004 i_reset  in  1  synchronous active-high reset.
REQ-005 i_start  in  1  start request; sampled only in IDLE.
REQ-006 i_src  in  32  source byte address, word aligned.
REQ-007 i_dst  in  32  destination byte address, word aligned.
REQ-008 i_len  in  LEN_W  transfer length in words.
REQ-009 i_fill  in  1  fill-mode select (see Configuration).
REQ-010 i_fill_data  in  32  fill pattern.
REQ-011 i_abort  in  1  terminate transfer.
REQ-012 i_gnt  in  1  bus grant from CPU/DMA arbiter.
REQ-013 o_req  out  1  bus request.
REQ-014 o_addr, o_wdata  out  32 each  LSU-side address and write data.
REQ-015 o_bmask  out  4  LSU access type; 4'b0100 = word load, 4'b1010 = word store.
REQ-016 o_wren  out  1  LSU write enable.
REQ-017 i_rdata  in  32  LSU read data, combinational from o_addr in the same cycle.
REQ-018 o_busy, o_done, o_err  out  1 each  status; o_count  out  LEN_W  words written.

Function
REQ-019 SHALL implement states IDLE, RD, WR, DONE.
REQ-020 IDLE + i_start: SHALL latch src, dst, len, fill, fill_data; clear o_count and o_err.
REQ-021 At start, if i_src[1:0]!=0 or i_dst[1:0]!=0 -> o_err=1, go DONE, issue no bus access.
REQ-022 At start, if len==0 -> go DONE, no bus access, o_err=0.
REQ-023 Otherwise -> RD (copy) or WR (fill).
REQ-024 RD with i_gnt: o_addr=src, o_bmask=4'b0100, o_wren=0; i_rdata registered into data buffer at edge; -> WR.
REQ-025 WR with i_gnt: o_addr=dst, o_wdata=buffer (fill: latched pattern), o_bmask=4'b1010, o_wren=1.
REQ-026 At the WR edge: src+=4 and dst+=4 (modulo 2^32, wrap allowed), o_count+=1, remaining-=1; remaining reaching 0 -> DONE, else RD (copy) / WR (fill).
REQ-027 i_gnt low in RD/WR: SHALL hold state and all counters; o_wren=0, o_bmask=0.
REQ-028 o_req=1 exactly in RD/WR; o_busy=1 exactly in RD/WR.
REQ-029 Outside granted RD/WR cycles: o_addr=0, o_wdata=0, o_bmask=0, o_wren=0.
REQ-030 i_abort in RD/WR SHALL take priority: o_wren forced 0 that cycle, no counter update, -> DONE; o_err=0; o_count keeps completed words.
REQ-031 DONE: o_done=1 for exactly one cycle, then -> IDLE; i_start during DONE ignored.
REQ-032 i_start while not IDLE SHALL be ignored; o_err and o_count hold until next accepted start.
REQ-033 Copy throughput: with i_gnt held high, start sampled at edge 0 -> o_done high in cycle 2N+1.

Reset
REQ-034 i_reset high at an edge SHALL force IDLE and zero o_count, o_err, buffer, and internal addresses/length, overriding every other input including mid-transfer.
REQ-035 During and after reset, all outputs SHALL be 0.

Configuration
REQ-036 Macro LSU_DMA_FILL_EN: when defined, i_fill=1 selects fill mode (no RD states, one word/cycle, o_done in cycle N+1 with grant held).
REQ-037 Without LSU_DMA_FILL_EN, i_fill and i_fill_data SHALL be ignored and every transfer is a copy.

Verification
REQ-038 Copy: src=0x0000_0100, dst=0x0000_0200, len=3, gnt=1 -> word loads at 0x100/0x104/0x108, stores at 0x200/0x204/0x208 with matching data, o_done in cycle 7, o_count=3.
REQ-039 Grant stall: len=2, gnt low cycles 2-4 -> no store while gnt low, accesses resume unchanged, o_done delayed by 3 cycles, o_count=2.
REQ-040 Error: src=0x0000_0102, len=4 -> no o_req, o_err=1, o_done one cycle after start, o_count=0.
REQ-041 Abort: len=8, i_abort in cycle 6 (WR of word 3) -> store suppressed, o_done next cycle, o_count=2.
REQ-042 Wrap: src=0xFFFF_FFFC, len=2 -> second load at 0x0000_0000.
REQ-043 Fill (macro defined): i_fill=1, data=0xDEAD_BEEF, dst=0x40, len=4 -> 4 consecutive stores 0x40-0x4C, o_done in cycle 5; same stimulus without macro performs a copy.
